// File: rtl/irrigation_pkg.sv
// irrigation_pkg
//   Shared definitions for the irrigation scheduler: FSM state codes,
//   valve method codes and a small helper for sizing the tick timer.
//   No ports (package only).
package irrigation_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_WATER = 2'd1,
        ST_SOAK  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic METHOD_DRIP   = 1'b0;
    localparam logic METHOD_SPRINK = 1'b1;

    // Timer width able to hold max(a,b)-1, never narrower than one bit.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/irrigation_tick_timer.sv
// irrigation_tick_timer
//   Tick-enabled up-counter with synchronous clear and an expiry flag that
//   fires on the tick that finds the count equal to the supplied limit.
//   Ports:
//     clk, reset_n  clock / asynchronous active-low reset
//     clr           synchronous clear (wins over tick)
//     tick          count enable
//     limit         last count value of the current interval (ticks-1)
//     count         current count
//     expired       tick arriving while count == limit
module irrigation_tick_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         tick,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         expired
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (tick) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count   = count_reg;
    assign expired = tick && (count_reg == limit);

endmodule

// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler
//   Sequences the irrigation valves: timed WATER burst, SOAK hold-off, then
//   back to IDLE. Burst method (dripper/sprinkler) is latched at burst start;
//   a sensor error forces all valves off via the FAULT state.
//   Optional macro IRRIGATION_FAULT_LATCH_EN: when defined FAULT is sticky and
//   needs fault_clear with error low to exit; otherwise FAULT exits on the
//   first cycle with error low.
//   Ports:
//     clk, reset_n      clock / asynchronous active-low reset
//     tick              1-cycle timebase enable
//     irrigation_mode   pre-requisites met
//     error             sensor fault (highest priority)
//     use_sprinkler     method request, 1 sprinkler / 0 dripper
//     fault_clear       fault acknowledge pulse
//     dripper_on        dripper valve drive
//     sprinkler_on      sprinkler valve drive
//     fault             high while in FAULT
//     state             IDLE=0 WATER=1 SOAK=2 FAULT=3
//     cycle_count       completed full bursts, saturating
module irrigation_scheduler
    import irrigation_pkg::*;
#(
    parameter int WATER_TICKS = 30,
    parameter int SOAK_TICKS  = 10,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             irrigation_mode,
    input  logic             error,
    input  logic             use_sprinkler,
    input  logic             fault_clear,
    output logic             dripper_on,
    output logic             sprinkler_on,
    output logic             fault,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int TW = timer_width(WATER_TICKS, SOAK_TICKS);
    localparam logic [TW-1:0] WATER_LIMIT = TW'(WATER_TICKS - 1);
    localparam logic [TW-1:0] SOAK_LIMIT  = TW'(SOAK_TICKS - 1);

    state_t           state_reg, state_next;
    logic             method_reg, method_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic             timer_clr;
    logic [TW-1:0]    timer_limit;
    logic [TW-1:0]    timer_count;
    logic             timer_expired;

    // Only WATER and SOAK time anything; any state change restarts the
    // interval so a tick coinciding with a transition is not carried over.
    assign timer_clr   = (state_next != state_reg) ||
                         (state_reg == ST_IDLE) || (state_reg == ST_FAULT);
    assign timer_limit = (state_reg == ST_WATER) ? WATER_LIMIT : SOAK_LIMIT;

    irrigation_tick_timer #(
        .W (TW)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (timer_clr),
        .tick    (tick),
        .limit   (timer_limit),
        .count   (timer_count),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            method_reg <= METHOD_DRIP;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            method_reg <= method_next;
            count_reg  <= count_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        method_next = method_reg;
        count_next  = count_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (error) begin
                    state_next = ST_FAULT;
                end else if (irrigation_mode) begin
                    state_next  = ST_WATER;
                    method_next = use_sprinkler;
                end
            end
            ST_WATER: begin
                if (error) begin
                    state_next = ST_FAULT;
                end else if (!irrigation_mode) begin
                    state_next = ST_SOAK;          // early stop, not counted
                end else if (timer_expired) begin
                    state_next = ST_SOAK;
                    if (count_reg != {CNT_W{1'b1}}) begin
                        count_next = count_reg + 1'b1;
                    end
                end
            end
            ST_SOAK: begin
                // irrigation_mode deliberately ignored to stop valve chatter
                if (error) begin
                    state_next = ST_FAULT;
                end else if (timer_expired) begin
                    state_next = ST_IDLE;
                end
            end
            ST_FAULT: begin
`ifdef IRRIGATION_FAULT_LATCH_EN
                if (fault_clear && !error) begin
                    state_next = ST_IDLE;
                end
`else
                if (!error) begin
                    state_next = ST_IDLE;
                end
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

`ifndef IRRIGATION_FAULT_LATCH_EN
    logic unused_fault_clear;
    logic [TW-1:0] unused_timer_count;
    assign unused_fault_clear = fault_clear;
    assign unused_timer_count = timer_count;
`else
    logic [TW-1:0] unused_timer_count;
    assign unused_timer_count = timer_count;
`endif

    // Outputs decode registered state only; no input reaches an output.
    assign dripper_on   = (state_reg == ST_WATER) && (method_reg == METHOD_DRIP);
    assign sprinkler_on = (state_reg == ST_WATER) && (method_reg == METHOD_SPRINK);
    assign fault        = (state_reg == ST_FAULT);
    assign state        = state_reg;
    assign cycle_count  = count_reg;

endmodule

// File: tb/tb_irrigation_scheduler.sv
module tb_irrigation_scheduler;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic       irrigation_mode = 1'b0;
    logic       error = 1'b0;
    logic       use_sprinkler = 1'b0;
    logic       fault_clear = 1'b0;
    logic       dripper_on, sprinkler_on, fault;
    logic [1:0] state;
    logic [1:0] cycle_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    irrigation_scheduler #(
        .WATER_TICKS (3),
        .SOAK_TICKS  (2),
        .CNT_W       (2)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .tick            (tick),
        .irrigation_mode (irrigation_mode),
        .error           (error),
        .use_sprinkler   (use_sprinkler),
        .fault_clear     (fault_clear),
        .dripper_on      (dripper_on),
        .sprinkler_on    (sprinkler_on),
        .fault           (fault),
        .state           (state),
        .cycle_count     (cycle_count)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One clock, then sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
    endtask

    task automatic check_outs(input string tag, input int st, input logic dr,
                              input logic sp, input logic ft);
        check({tag, ".state"}, 8'(state), 8'(st));
        check({tag, ".drip"}, 8'(dripper_on), 8'(dr));
        check({tag, ".sprink"}, 8'(sprinkler_on), 8'(sp));
        check({tag, ".fault"}, 8'(fault), 8'(ft));
    endtask

    task automatic leave_fault();
        error = 1'b0;
`ifdef IRRIGATION_FAULT_LATCH_EN
        fault_clear = 1'b1;
        step();
        fault_clear = 1'b0;
`else
        step();
`endif
    endtask

    initial begin
        // Reset state
        #2;
        check_outs("reset", 0, 0, 0, 0);
        check("reset.count", 8'(cycle_count), 8'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("post_reset.st", 8'(state), 8'd0);

        // Nominal drip with mid-burst method toggle
        irrigation_mode = 1'b1;
        use_sprinkler   = 1'b0;
        step();
        check_outs("drip.enter", 1, 1, 0, 0);
        pulse_tick(1);
        use_sprinkler = 1'b1;
        step();
        check_outs("drip.latch", 1, 1, 0, 0);
        pulse_tick(1);
        check_outs("drip.t2", 1, 1, 0, 0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check_outs("drip.soak", 2, 0, 0, 0);
        check("drip.count", 8'(cycle_count), 8'd1);
        irrigation_mode = 1'b0;
        pulse_tick(1);
        check("drip.soak1", 8'(state), 8'd2);
        pulse_tick(1);
        check("drip.idle", 8'(state), 8'd0);

        // Early stop with sprinkler
        use_sprinkler   = 1'b1;
        irrigation_mode = 1'b1;
        step();
        check_outs("early.enter", 1, 0, 1, 0);
        pulse_tick(1);
        irrigation_mode = 1'b0;
        step();
        check_outs("early.soak", 2, 0, 0, 0);
        check("early.count", 8'(cycle_count), 8'd1);
        pulse_tick(1);
        check("early.soak1", 8'(state), 8'd2);
        pulse_tick(1);
        check("early.idle", 8'(state), 8'd0);

        // Fault from WATER
        irrigation_mode = 1'b1;
        step();
        check("fault.water", 8'(state), 8'd1);
        error = 1'b1;
        irrigation_mode = 1'b0;
        step();
        check_outs("fault.enter", 3, 0, 0, 1);
`ifdef IRRIGATION_FAULT_LATCH_EN
        error = 1'b0;
        step();
        check("fault.sticky", 8'(state), 8'd3);
        error = 1'b1;
        fault_clear = 1'b1;
        step();
        fault_clear = 1'b0;
        check("fault.clr_err", 8'(state), 8'd3);
        error = 1'b0;
        fault_clear = 1'b1;
        step();
        fault_clear = 1'b0;
        check("fault.cleared", 8'(state), 8'd0);
`else
        error = 1'b0;
        step();
        check_outs("fault.exit", 0, 0, 0, 0);
`endif

        // Error coinciding with the final WATER tick
        irrigation_mode = 1'b1;
        step();
        pulse_tick(2);
        check("simul.water", 8'(state), 8'd1);
        tick  = 1'b1;
        error = 1'b1;
        step();
        tick  = 1'b0;
        irrigation_mode = 1'b0;
        check("simul.state", 8'(state), 8'd3);
        check("simul.count", 8'(cycle_count), 8'd1);
        leave_fault();
        check("simul.idle", 8'(state), 8'd0);

        // Five full bursts: count saturates at 3
        for (int b = 0; b < 5; b++) begin
            irrigation_mode = 1'b1;
            step();
            pulse_tick(3);
            irrigation_mode = 1'b0;
            check("sat.soak", 8'(state), 8'd2);
            check("sat.count", 8'(cycle_count), 8'((b + 2 > 3) ? 3 : b + 2));
            pulse_tick(2);
        end
        check("sat.idle", 8'(state), 8'd0);

        // Asynchronous reset mid-WATER
        use_sprinkler   = 1'b0;
        irrigation_mode = 1'b1;
        step();
        pulse_tick(1);
        check("arst.water", 8'(dripper_on), 8'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_outs("arst.low", 0, 0, 0, 0);
        check("arst.count", 8'(cycle_count), 8'd0);
        irrigation_mode = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("arst.idle", 8'(state), 8'd0);
        check("arst.count2", 8'(cycle_count), 8'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
